clock_set_ctrl: RTL and testbench

Sequencing controller for the Millennium Clock's calendar/time counters. It owns the run/set mode and selects which field (year, month, day, hour, minute) is being adjusted. It converts the debounced mode/inc/dec buttons into single-cycle, auto-repeating adjust strobes for the selected counter, and it gates the 1 s count enable while the user is in set mode.

---
 rtl/clock_set_ctrl.sv | 156 +++++++++++++++
 tb/tb_clock_set_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Run/set sequencer for the clock's calendar counters: mode FSM, auto-repeating
// inc/dec strobes for the selected field, idle timeout and blink phase.
module clock_set_ctrl #(
  parameter int unsigned HOLD_CYC   = 25_000_000,
  parameter int unsigned REPEAT_CYC = 5_000_000,
  parameter int unsigned TIMEOUT_S  = 30
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tick_1s,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic       count_en,
  output logic       set_enable,
  output logic [4:0] field_sel,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       blink
);

  localparam logic [2:0] S_RUN   = 3'd0;
  localparam logic [2:0] S_YEAR  = 3'd1;
  localparam logic [2:0] S_MONTH = 3'd2;
  localparam logic [2:0] S_DAY   = 3'd3;
  localparam logic [2:0] S_HOUR  = 3'd4;
  localparam logic [2:0] S_MIN   = 3'd5;

  // Button history, bit order {mode, inc, dec}
  logic [2:0]  btn_q, btn_qq;
  logic [2:0]  state_q, state_d;
  logic [31:0] hold_q, hold_d, thr;
  logic        rep_q, rep_d;
  logic        act_inc_q, act_inc_d, act_dec_q, act_dec_d;
  logic        fire_inc_q, fire_inc_d, fire_dec_q, fire_dec_d;
  logic        blink_q, blink_d;
  logic [5:0]  idle_q, idle_d;
  logic        mode_rise, inc_rise, dec_rise, in_set, timeout, fire_any;
  logic [4:0]  fsel;

  assign mode_rise = btn_q[2] & ~btn_qq[2];
  assign inc_rise  = btn_q[1] & ~btn_qq[1];
  assign dec_rise  = btn_q[0] & ~btn_qq[0];
  assign in_set    = (state_q != S_RUN);
  assign fire_any  = fire_inc_d | fire_dec_d;

  always_comb begin
    fire_inc_d = 1'b0;
    fire_dec_d = 1'b0;
    act_inc_d  = 1'b0;
    act_dec_d  = 1'b0;
    hold_d     = '0;
    rep_d      = 1'b0;
    thr        = rep_q ? REPEAT_CYC : HOLD_CYC;
    // A mode edge swallows any coincident inc/dec edge; both held cancels everything.
    if (in_set && !mode_rise && !(btn_q[1] && btn_q[0])) begin
      if (inc_rise) begin
        fire_inc_d = 1'b1;
        act_inc_d  = 1'b1;
        hold_d     = 32'd1;
      end else if (dec_rise) begin
        fire_dec_d = 1'b1;
        act_dec_d  = 1'b1;
        hold_d     = 32'd1;
      end else if ((act_inc_q && btn_q[1]) || (act_dec_q && btn_q[0])) begin
        act_inc_d = act_inc_q;
        act_dec_d = act_dec_q;
        rep_d     = rep_q;
        if (hold_q == thr) begin
          fire_inc_d = act_inc_q;
          fire_dec_d = act_dec_q;
          hold_d     = 32'd1;
          rep_d      = 1'b1;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
    end

    // A strobe counts as activity, so it outranks a coincident timeout tick.
    timeout = in_set && !mode_rise && !fire_any && tick_1s &&
              ((32'(idle_q) + 32'd1) >= TIMEOUT_S);

    state_d = state_q;
    if (mode_rise)    state_d = (state_q == S_MIN) ? S_RUN : state_q + 3'd1;
    else if (timeout) state_d = S_RUN;

    if (state_d != state_q) begin
      act_inc_d = 1'b0;
      act_dec_d = 1'b0;
      hold_d    = '0;
      rep_d     = 1'b0;
    end

    idle_d = idle_q;
    if (state_d == S_RUN || mode_rise || fire_any) idle_d = '0;
    else if (tick_1s && idle_q != 6'h3f)           idle_d = idle_q + 6'd1;

    blink_d = blink_q;
    if (state_d == S_RUN)          blink_d = 1'b0;
    else if (state_d != state_q)   blink_d = 1'b1;
    else if (tick_1s)              blink_d = ~blink_q;

    case (state_q)
      S_YEAR:  fsel = 5'b10000;
      S_MONTH: fsel = 5'b01000;
      S_DAY:   fsel = 5'b00100;
      S_HOUR:  fsel = 5'b00010;
      S_MIN:   fsel = 5'b00001;
      default: fsel = 5'b00000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      btn_q      <= '0;
      btn_qq     <= '0;
      state_q    <= S_RUN;
      hold_q     <= '0;
      rep_q      <= 1'b0;
      act_inc_q  <= 1'b0;
      act_dec_q  <= 1'b0;
      fire_inc_q <= 1'b0;
      fire_dec_q <= 1'b0;
      blink_q    <= 1'b0;
      idle_q     <= '0;
      count_en   <= 1'b0;
      set_enable <= 1'b0;
      field_sel  <= '0;
      inc_pulse  <= 1'b0;
      dec_pulse  <= 1'b0;
      blink      <= 1'b0;
    end else begin
      btn_q      <= {btn_mode, btn_inc, btn_dec};
      btn_qq     <= btn_q;
      state_q    <= state_d;
      hold_q     <= hold_d;
      rep_q      <= rep_d;
      act_inc_q  <= act_inc_d;
      act_dec_q  <= act_dec_d;
      fire_inc_q <= fire_inc_d;
      fire_dec_q <= fire_dec_d;
      blink_q    <= blink_d;
      idle_q     <= idle_d;
      // Gating on the pre-transition state forwards a tick on the exit from RUN
      // and drops it on re-entry.
      count_en   <= tick_1s & ~in_set;
      set_enable <= in_set;
      field_sel  <= fsel;
      inc_pulse  <= fire_inc_q;
      dec_pulse  <= fire_dec_q;
      blink      <= blink_q;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: a behavioural model pushes expected outputs
// per clock, a negedge monitor pops and compares; directed phases then random traffic.
module tb_clock_set_ctrl;
  localparam int HOLD = 8;
  localparam int REP  = 3;
  localparam int TMO  = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0, tick_1s = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic count_en, set_enable, inc_pulse, dec_pulse, blink;
  logic [4:0] field_sel;

  clock_set_ctrl #(.HOLD_CYC(HOLD), .REPEAT_CYC(REP), .TIMEOUT_S(TMO)) dut (
    .clk(clk), .rstn(rstn), .tick_1s(tick_1s), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .btn_dec(btn_dec), .count_en(count_en), .set_enable(set_enable), .field_sel(field_sel),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .blink(blink)
  );

  always #5 clk = ~clk;

  logic [9:0] exp_q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int n_cen = 0, n_inc = 0, n_dec = 0;
  int chk_id = 0, seen_id = 0, chk_got = 0, chk_want = 0;
  string chk_name = "";

  // Model state: field index 0=RUN,1=year..5=minute; seq 0=none,1=inc,2=dec.
  int m_mode = 0, m_idle = 0, m_seq = 0, m_age = 0;
  logic m_blink = 1'b0, m_fi = 1'b0, m_fd = 1'b0;
  logic [2:0] p1 = '0, p2 = '0;

  function automatic logic [4:0] sel_of(input int m);
    return (m == 0) ? 5'b0 : 5'(1 << (5 - m));
  endfunction

  // Expected outputs after this edge, then the user-level reaction to buttons
  // seen two samples back and to the tick present now.
  task automatic model();
    logic mr, ir, dr;
    int nm;
    if (!rstn) begin
      exp_q.push_back('0);
      m_mode = 0; m_idle = 0; m_seq = 0; m_age = 0;
      m_blink = 0; m_fi = 0; m_fd = 0; p1 = '0; p2 = '0;
      return;
    end
    exp_q.push_back({tick_1s && m_mode == 0, m_mode != 0, sel_of(m_mode), m_fi, m_fd, m_blink});
    mr = p1[2] & ~p2[2];
    ir = p1[1] & ~p2[1];
    dr = p1[0] & ~p2[0];
    m_fi = 0; m_fd = 0;
    if (m_mode != 0 && !mr) begin
      if (p1[1] && p1[0]) m_seq = 0;
      else if (ir) begin m_fi = 1; m_seq = 1; m_age = 0; end
      else if (dr) begin m_fd = 1; m_seq = 2; m_age = 0; end
      else if ((m_seq == 1 && p1[1]) || (m_seq == 2 && p1[0])) begin
        m_age++;
        if (m_age == HOLD || (m_age > HOLD && (m_age - HOLD) % REP == 0)) begin
          m_fi = (m_seq == 1);
          m_fd = (m_seq == 2);
        end
      end else m_seq = 0;
    end else m_seq = 0;
    nm = m_mode;
    if (mr) begin
      nm = (m_mode + 1) % 6;
      m_idle = 0;
    end else if (m_mode != 0) begin
      if (m_fi || m_fd) m_idle = 0;
      else if (tick_1s) begin
        if (m_idle < 63) m_idle++;
        if (m_idle >= TMO) nm = 0;
      end
    end
    if (nm == 0) begin m_blink = 0; m_idle = 0; end
    else if (nm != m_mode) m_blink = 1;
    else if (tick_1s) m_blink = ~m_blink;
    if (nm != m_mode) m_seq = 0;
    m_mode = nm;
    p2 = p1;
    p1 = {btn_mode, btn_inc, btn_dec};
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model();
      #1;
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    chk_name = name; chk_got = got; chk_want = want;
    chk_id++;
    step(1);
  endtask

  task automatic press_mode();
    btn_mode = 1; step(2); btn_mode = 0; step(4);
  endtask

  task automatic tick();
    tick_1s = 1; step(1); tick_1s = 0; step(4);
  endtask

  always @(negedge clk) begin
    logic [9:0] want, got;
    cyc <= cyc + 1;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {count_en, set_enable, field_sel, inc_pulse, dec_pulse, blink};
      n_cmp <= n_cmp + 1;
      if (got !== want) begin
        n_bad <= n_bad + 1;
        $display("FAIL outputs cyc=%0d {cen,set,sel,inc,dec,blink} got=%b want=%b", cyc, got, want);
      end
      n_cen <= n_cen + int'(count_en === 1'b1);
      n_inc <= n_inc + int'(inc_pulse === 1'b1);
      n_dec <= n_dec + int'(dec_pulse === 1'b1);
    end
    if (chk_id != seen_id) begin
      seen_id <= chk_id;
      n_cmp <= n_cmp + 2;
      if (chk_got != chk_want) begin
        n_bad <= n_bad + 1;
        $display("FAIL %s got=%0d want=%0d", chk_name, chk_got, chk_want);
      end
    end
  end

  initial begin
    int b_cen, b_inc, b_dec;
    step(3);
    rstn = 1;
    step(2);

    b_cen = n_cen;
    repeat (5) tick();
    chk("run_ticks_count_en", n_cen - b_cen, 5);

    repeat (6) press_mode();
    step(2);

    // Year: hold long enough for the first strobe plus three repeats only.
    press_mode();
    b_inc = n_inc; b_dec = n_dec;
    btn_inc = 1; step(17); btn_inc = 0; step(6);
    chk("year_hold_inc_strobes", n_inc - b_inc, 4);
    chk("year_hold_dec_strobes", n_dec - b_dec, 0);

    // Day: both held, then dec released with inc still down.
    press_mode(); press_mode();
    b_inc = n_inc; b_dec = n_dec;
    btn_inc = 1; btn_dec = 1; step(10);
    btn_dec = 0; step(14);
    btn_inc = 0; step(4);
    chk("day_conflict_strobes", (n_inc - b_inc) + (n_dec - b_dec), 0);

    // Hour: idle timeout on the 4th tick, 5th tick forwarded.
    press_mode();
    b_cen = n_cen;
    repeat (4) tick();
    chk("timeout_tick_dropped", n_cen - b_cen, 0);
    tick();
    chk("after_timeout_tick", n_cen - b_cen, 1);

    // Month: reset in the middle of auto-repeat with inc still held.
    press_mode(); press_mode();
    btn_inc = 1; step(14);
    rstn = 0; step(1); rstn = 1;
    b_inc = n_inc;
    step(20);
    btn_inc = 0; step(3);
    chk("post_reset_no_strobes", n_inc - b_inc, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(9) == 0)  btn_inc  = ~btn_inc;
      if ($urandom_range(9) == 0)  btn_dec  = ~btn_dec;
      tick_1s = ($urandom_range(11) == 0);
      rstn    = ($urandom_range(599) != 0);
      step(1);
    end
    rstn = 1; tick_1s = 0; btn_mode = 0; btn_inc = 0; btn_dec = 0;
    step(4);
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
